axis_rr_arbiter: RTL and testbench
==================================

Name: axis_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one AXI-Stream sink (the axis_fifo write port) among NUM_PORTS AXI-Stream requesters.
- Selects one requester, locks the grant until that requester's tlast beat is accepted downstream, then rotates priority.
- Sits directly in front of axis_fifo's s_axis_* interface; the downstream stream is never interleaved within a packet.

Parameters:
NUM_PORTS, 4, number of requester ports (2..16)
DATA_WIDTH, 8, tdata width per port
KEEP_WIDTH, 1, tkeep width per port
CNT_WIDTH, 16, width of packet counter

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  synchronous reset, active-high
s_axis_tvalid  in  NUM_PORTS  per-port valid, bit i = port i
s_axis_tready  out  NUM_PORTS  per-port ready
s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  port i at [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tkeep  in  NUM_PORTS*KEEP_WIDTH  port i at [i*KEEP_WIDTH +: KEEP_WIDTH]
s_axis_tlast  in  NUM_PORTS  per-port last
m_axis_tvalid  out  1  to axis_fifo s_axis_tvalid
m_axis_tready  in  1  from axis_fifo (tready)
m_axis_tdata  out  DATA_WIDTH  selected data
m_axis_tkeep  out  KEEP_WIDTH  selected keep
m_axis_tlast  out  1  selected last
grant_valid  out  1  1 while a packet grant is held (state BUSY)
grant_idx  out  clog2(NUM_PORTS)  currently/last granted port
pkt_count  out  CNT_WIDTH  completed packets since reset

Behaviour:
- Reset (areset high at posedge): state=IDLE, rr_ptr=0, grant_idx=0, grant_valid=0, pkt_count=0. While areset is high, m_axis_tvalid and all s_axis_tready are forced 0 combinationally; m_axis_tdata/tkeep/tlast = 0.
- States: IDLE, BUSY.
- IDLE: all s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0. If any s_axis_tvalid bit is set, pick the first set bit searching rr_ptr, rr_ptr+1, ... wrapping modulo NUM_PORTS. Register grant_idx, set grant_valid, go to BUSY. Arbitration costs exactly one cycle; no beat transfers in IDLE.
- BUSY:
  - m_axis_tvalid/tdata/tkeep/tlast = port[grant_idx] signals, combinational mux, zero latency.
  - s_axis_tready[grant_idx] = m_axis_tready; all other tready bits = 0.
  - A beat transfers when m_axis_tvalid & m_axis_tready.
  - On a transfer with m_axis_tlast=1: go to IDLE, rr_ptr = (grant_idx+1) mod NUM_PORTS, pkt_count += 1 (wraps at 2^CNT_WIDTH), grant_valid=0. grant_idx keeps its value.
- Grant lock: once granted, a port keeps the grant until its tlast transfer, even if it deasserts tvalid mid-packet. Other ports' requests are ignored in BUSY.
- Backpressure: m_axis_tready=0 holds the granted port stalled via its tready. The arbiter stores no data; AXIS stability is the requester's obligation.
- Single-beat packet: grant cycle, then one BUSY cycle (if ready), then IDLE. Sustained peak: one idle bubble per packet.
- Fairness: with all ports continuously requesting, the grant sequence is 0,1,...,NUM_PORTS-1,0,... A port waits at most NUM_PORTS-1 packets.
- No requests: remain in IDLE; rr_ptr unchanged.
- Reset mid-packet: the packet is abandoned (no tlast emitted), counters cleared, next grant searches from port 0.

Test Plan:
- Reset: areset=1 for 5 cycles, all s_axis_tvalid=1 -> m_axis_tvalid=0, s_axis_tready=0, grant_valid=0, pkt_count=0 throughout.
- Single port: port 2 sends 0x11,0x22,0x33(tlast), m_axis_tready=1 -> grant_idx=2 one cycle after tvalid; m_axis_tdata 0x11,0x22,0x33 on 3 consecutive cycles; pkt_count=1; rr_ptr=3.
- Fairness: all 4 ports send continuous 2-beat packets, ready=1 -> grant order 0,1,2,3,0,1; pkt_count=6 after 18 cycles (3 cycles per packet).
- Backpressure: m_axis_tready=0 for 4 cycles after beat 1 of a 3-beat packet -> granted s_axis_tready=0 for those cycles, m_axis_tdata stable, all 3 beats delivered in order with none lost.
- Grant lock: port 1 drops tvalid for 3 cycles mid-packet while port 3 requests -> grant_idx stays 1, s_axis_tready[3]=0; port 3 is granted only after port 1's tlast.
- Reset mid-packet: assert areset during beat 2 of port 2's packet, with ports 0 and 2 requesting afterwards -> next grant_idx=0, pkt_count=0.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter: shares one AXI-Stream sink among NUM_PORTS requesters.
// A grant is held from arbitration until the granted port's tlast beat is accepted.
module axis_rr_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 8,
   parameter int KEEP_WIDTH = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                             aclk,
   input  logic                             areset,
   input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
   output logic [NUM_PORTS-1:0]             s_axis_tready,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
   input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
   input  logic [NUM_PORTS-1:0]             s_axis_tlast,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic [DATA_WIDTH-1:0]            m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
   output logic                             m_axis_tlast,
   output logic                             grant_valid,
   output logic [$clog2(NUM_PORTS)-1:0]     grant_idx,
   output logic [CNT_WIDTH-1:0]             pkt_count
);

   localparam int IDX_W = $clog2(NUM_PORTS);

   // Handshake: a beat moves on a rising edge where valid and ready are both high;
   // ready from the sink is passed only to the granted port, valid/data never wait on ready.

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                 state, state_next;
   logic [IDX_W-1:0]       rr_ptr, rr_ptr_next;
   logic [IDX_W-1:0]       grant_idx_next;
   logic [CNT_WIDTH-1:0]   pkt_count_next;

   logic                   pick_found;
   logic [IDX_W-1:0]       pick_idx;
   logic [IDX_W:0]         cand_sum;
   logic [IDX_W-1:0]       cand;

   logic                   sel_valid;
   logic [DATA_WIDTH-1:0]  sel_data;
   logic [KEEP_WIDTH-1:0]  sel_keep;
   logic                   sel_last;

   // grant_valid is the externally visible FSM state
   assign grant_valid = (state == BUSY);

   assign sel_valid = s_axis_tvalid[grant_idx];
   assign sel_data  = s_axis_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
   assign sel_keep  = s_axis_tkeep[grant_idx*KEEP_WIDTH +: KEEP_WIDTH];
   assign sel_last  = s_axis_tlast[grant_idx];

   // Search rr_ptr, rr_ptr+1, ... modulo NUM_PORTS; the extra sum bit keeps the wrap exact
   // for non power-of-two port counts.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand_sum   = '0;
      cand       = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
         if (cand_sum >= (IDX_W+1)'(NUM_PORTS))
            cand_sum = cand_sum - (IDX_W+1)'(NUM_PORTS);
         cand = cand_sum[IDX_W-1:0];
         if (!pick_found && s_axis_tvalid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      state_next     = state;
      rr_ptr_next    = rr_ptr;
      grant_idx_next = grant_idx;
      pkt_count_next = pkt_count;
      s_axis_tready  = '0;
      m_axis_tvalid  = 1'b0;
      m_axis_tdata   = '0;
      m_axis_tkeep   = '0;
      m_axis_tlast   = 1'b0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               grant_idx_next = pick_idx;
               state_next     = BUSY;
            end
         end
         BUSY: begin
            if (!areset) begin
               m_axis_tvalid            = sel_valid;
               m_axis_tdata             = sel_data;
               m_axis_tkeep             = sel_keep;
               m_axis_tlast             = sel_last;
               s_axis_tready[grant_idx] = m_axis_tready;
            end
            if (sel_valid && m_axis_tready && sel_last) begin
               state_next     = IDLE;
               rr_ptr_next    = (grant_idx == IDX_W'(NUM_PORTS-1)) ? '0 : grant_idx + 1'b1;
               pkt_count_next = pkt_count + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         grant_idx <= '0;
         pkt_count <= '0;
      end else begin
         state     <= state_next;
         rr_ptr    <= rr_ptr_next;
         grant_idx <= grant_idx_next;
         pkt_count <= pkt_count_next;
      end
   end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: per-port packet queues feed the DUT, expected beats
// go into a scoreboard queue that a negedge monitor drains on every accepted beat.
module tb_axis_rr_arbiter;

   localparam int NP = 4;
   localparam int DW = 8;

   logic            aclk;
   logic            areset;
   logic [NP-1:0]   s_axis_tvalid;
   logic [NP-1:0]   s_axis_tready;
   logic [NP*DW-1:0] s_axis_tdata;
   logic [NP-1:0]   s_axis_tkeep;
   logic [NP-1:0]   s_axis_tlast;
   logic            m_axis_tvalid;
   logic            m_axis_tready;
   logic [DW-1:0]   m_axis_tdata;
   logic [0:0]      m_axis_tkeep;
   logic            m_axis_tlast;
   logic            grant_valid;
   logic [1:0]      grant_idx;
   logic [15:0]     pkt_count;

   axis_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(1), .CNT_WIDTH(16)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .grant_valid   (grant_valid),
      .grant_idx     (grant_idx),
      .pkt_count     (pkt_count)
   );

   // clock / reset
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   int n_cmp = 0;
   int n_err = 0;

   logic [8:0]  port_q [NP][$];   // {tlast, tdata} per requester
   logic [10:0] exp_q[$];         // {grant_idx, tlast, tdata}
   logic [10:0] exp_e;
   logic [NP-1:0] hold;           // forces a requester's tvalid low mid-packet

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic step();
      @(negedge aclk);
   endtask

   task automatic drive_edge();
      @(posedge aclk);
      #2;
   endtask

   task automatic beat(input int p, input logic [7:0] d, input logic l);
      port_q[p].push_back({l, d});
   endtask

   task automatic expect_beat(input int p, input logic [7:0] d, input logic l);
      logic [1:0] pi;
      pi = 2'(p);
      exp_q.push_back({pi, l, d});
   endtask

   task automatic wait_grant(input string name);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!grant_valid && n < 20);
      if (!grant_valid) chk({name, "_grant_timeout"}, 32'(grant_valid), 32'd1);
   endtask

   task automatic drain(input string name);
      int n;
      bit busy;
      n = 0;
      do begin
         step();
         n++;
         busy = (exp_q.size() != 0) || grant_valid;
         for (int i = 0; i < NP; i++) if (port_q[i].size() != 0) busy = 1'b1;
      end while (busy && n < 300);
      if (busy) chk({name, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
   endtask

   // requester driver: handshakes seen at negedge retire beats after the next rising edge
   initial begin
      logic [NP-1:0] fire;
      s_axis_tvalid = '0;
      s_axis_tdata  = '0;
      s_axis_tlast  = '0;
      s_axis_tkeep  = '1;
      forever begin
         @(negedge aclk);
         fire = s_axis_tvalid & s_axis_tready;
         @(posedge aclk);
         #1;
         for (int i = 0; i < NP; i++) begin
            if (fire[i] && port_q[i].size() != 0) void'(port_q[i].pop_front());
            if (port_q[i].size() != 0 && !hold[i]) begin
               s_axis_tvalid[i]          = 1'b1;
               s_axis_tdata[i*DW +: DW]  = port_q[i][0][7:0];
               s_axis_tlast[i]           = port_q[i][0][8];
            end else begin
               s_axis_tvalid[i]          = 1'b0;
               s_axis_tdata[i*DW +: DW]  = '0;
               s_axis_tlast[i]           = 1'b0;
            end
         end
      end
   end

   // scoreboard monitor
   always @(negedge aclk) begin
      if (!areset && m_axis_tvalid && m_axis_tready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL beat_unexpected: got port %0d data %0h last %0b, required no beat", grant_idx, m_axis_tdata, m_axis_tlast);
         end else begin
            exp_e = exp_q.pop_front();
            if ({grant_idx, m_axis_tlast, m_axis_tdata} !== exp_e || m_axis_tkeep !== 1'b1 ||
                s_axis_tready[grant_idx] !== 1'b1) begin
               n_err++;
               $display("FAIL beat: got port %0d last %0b data %0h keep %0b rdy %0b, required port %0d last %0b data %0h",
                        grant_idx, m_axis_tlast, m_axis_tdata, m_axis_tkeep, s_axis_tready[grant_idx],
                        exp_e[10:9], exp_e[8], exp_e[7:0]);
            end
         end
      end
   end

   initial begin
      areset        = 1'b1;
      m_axis_tready = 1'b1;
      hold          = '0;

      // reset with every port requesting a single-beat packet
      for (int i = 0; i < NP; i++) begin
         beat(i, 8'(i + 1), 1'b1);
         expect_beat(i, 8'(i + 1), 1'b1);
      end
      repeat (6) begin
         step();
         chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
         chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
         chk("rst_grant_valid", 32'(grant_valid), 32'd0);
         chk("rst_pkt_count", 32'(pkt_count), 32'd0);
      end
      chk("rst_s_tvalid_seen", 32'(s_axis_tvalid), 32'hF);
      drive_edge();
      areset = 1'b0;
      drain("rst");
      chk("rst_pkt_after", 32'(pkt_count), 32'd4);

      // fairness: all ports requesting 2-beat packets
      beat(0, 8'h10, 1'b0); beat(0, 8'h11, 1'b1); beat(0, 8'h14, 1'b0); beat(0, 8'h15, 1'b1);
      beat(1, 8'h20, 1'b0); beat(1, 8'h21, 1'b1); beat(1, 8'h24, 1'b0); beat(1, 8'h25, 1'b1);
      beat(2, 8'h30, 1'b0); beat(2, 8'h31, 1'b1);
      beat(3, 8'h40, 1'b0); beat(3, 8'h41, 1'b1);
      expect_beat(0, 8'h10, 1'b0); expect_beat(0, 8'h11, 1'b1);
      expect_beat(1, 8'h20, 1'b0); expect_beat(1, 8'h21, 1'b1);
      expect_beat(2, 8'h30, 1'b0); expect_beat(2, 8'h31, 1'b1);
      expect_beat(3, 8'h40, 1'b0); expect_beat(3, 8'h41, 1'b1);
      expect_beat(0, 8'h14, 1'b0); expect_beat(0, 8'h15, 1'b1);
      expect_beat(1, 8'h24, 1'b0); expect_beat(1, 8'h25, 1'b1);
      step();
      chk("fair_arb_cycle", 32'(grant_valid), 32'd0);
      repeat (17) step();
      chk("fair_pkt_17", 32'(pkt_count), 32'd9);
      step();
      chk("fair_pkt_18", 32'(pkt_count), 32'd10);
      drain("fair");

      // single port 2, three beats
      beat(2, 8'h11, 1'b0); beat(2, 8'h22, 1'b0); beat(2, 8'h33, 1'b1);
      expect_beat(2, 8'h11, 1'b0); expect_beat(2, 8'h22, 1'b0); expect_beat(2, 8'h33, 1'b1);
      step();
      chk("single_idle_valid", 32'(m_axis_tvalid), 32'd0);
      chk("single_idle_ready", 32'(s_axis_tready), 32'd0);
      step();
      chk("single_grant_idx", 32'(grant_idx), 32'd2);
      chk("single_d0", 32'(m_axis_tdata), 32'h11);
      step();
      chk("single_d1", 32'(m_axis_tdata), 32'h22);
      step();
      chk("single_d2", 32'({m_axis_tlast, m_axis_tdata}), 32'h133);
      step();
      chk("single_done", 32'(grant_valid), 32'd0);
      chk("single_pkt", 32'(pkt_count), 32'd11);

      // rr_ptr is now 3: port 3 must win over port 0
      beat(0, 8'h61, 1'b1); beat(3, 8'h62, 1'b1);
      expect_beat(3, 8'h62, 1'b1); expect_beat(0, 8'h61, 1'b1);
      drain("rrptr");
      chk("rrptr_pkt", 32'(pkt_count), 32'd13);

      // reset mid-packet on port 2 while rr_ptr=1; afterwards ports 0 and 2 request
      beat(2, 8'h91, 1'b0); beat(2, 8'h92, 1'b0); beat(2, 8'h93, 1'b1);
      expect_beat(2, 8'h91, 1'b0);
      wait_grant("rstmid");
      chk("rstmid_first_idx", 32'(grant_idx), 32'd2);
      drive_edge();
      areset = 1'b1;
      beat(0, 8'hA1, 1'b1);
      expect_beat(0, 8'hA1, 1'b1); expect_beat(2, 8'h92, 1'b0); expect_beat(2, 8'h93, 1'b1);
      step();
      chk("rstmid_force_valid", 32'(m_axis_tvalid), 32'd0);
      chk("rstmid_force_ready", 32'(s_axis_tready), 32'd0);
      drive_edge();
      areset = 1'b0;
      step();
      chk("rstmid_pkt_clear", 32'(pkt_count), 32'd0);
      chk("rstmid_idle", 32'(grant_valid), 32'd0);
      wait_grant("rstmid2");
      chk("rstmid_next_idx", 32'(grant_idx), 32'd0);
      drain("rstmid");
      chk("rstmid_pkt", 32'(pkt_count), 32'd2);

      // backpressure: sink stalls 4 cycles after beat 1
      beat(0, 8'h81, 1'b0); beat(0, 8'h82, 1'b0); beat(0, 8'h83, 1'b1);
      expect_beat(0, 8'h81, 1'b0); expect_beat(0, 8'h82, 1'b0); expect_beat(0, 8'h83, 1'b1);
      wait_grant("bp");
      chk("bp_idx", 32'(grant_idx), 32'd0);
      drive_edge();
      m_axis_tready = 1'b0;
      repeat (4) begin
         step();
         chk("bp_s_tready", 32'(s_axis_tready), 32'd0);
         chk("bp_m_tvalid", 32'(m_axis_tvalid), 32'd1);
         chk("bp_data_stable", 32'(m_axis_tdata), 32'h82);
      end
      drive_edge();
      m_axis_tready = 1'b1;
      drain("bp");
      chk("bp_pkt", 32'(pkt_count), 32'd3);

      // grant lock: port 1 drops tvalid mid-packet while port 3 requests
      beat(1, 8'h51, 1'b0); beat(1, 8'h52, 1'b0); beat(1, 8'h53, 1'b1);
      expect_beat(1, 8'h51, 1'b0); expect_beat(1, 8'h52, 1'b0); expect_beat(1, 8'h53, 1'b1);
      expect_beat(3, 8'h71, 1'b1);
      wait_grant("lock");
      chk("lock_idx", 32'(grant_idx), 32'd1);
      drive_edge();
      hold[1] = 1'b1;
      beat(3, 8'h71, 1'b1);
      drive_edge();
      repeat (3) begin
         step();
         chk("lock_grant_valid", 32'(grant_valid), 32'd1);
         chk("lock_grant_idx", 32'(grant_idx), 32'd1);
         chk("lock_p3_ready", 32'(s_axis_tready[3]), 32'd0);
         chk("lock_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      end
      hold[1] = 1'b0;
      drain("lock");
      chk("lock_pkt", 32'(pkt_count), 32'd5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
